// File: rtl/calc_stack_display_ctrl.sv
// Calculator operand stack with command sequencing and display snapshot bus.
// Optional CALC_FRAME_SYNC_EN: numbers reloads only on the vblank rising edge.
module calc_stack_display_ctrl #(
  parameter int unsigned     DEPTH        = 15,
  parameter int unsigned     W            = 4,
  parameter logic [W-1:0]    EMPTY_NIBBLE = 4'hF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [W-1:0]         cmd_data,
  input  logic                 vblank,
  output logic [DEPTH*W-1:0]   numbers,
  output logic [3:0]           depth,
  output logic [W-1:0]         top,
  output logic                 err_ovf,
  output logic                 err_unf
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
  typedef enum logic [2:0] {
    OP_PUSH  = 3'd0,
    OP_POP   = 3'd1,
    OP_ADD   = 3'd2,
    OP_SUB   = 3'd3,
    OP_MUL   = 3'd4,
    OP_CLEAR = 3'd5,
    OP_RSV6  = 3'd6,
    OP_RSV7  = 3'd7
  } op_t;

  state_t             state, state_nxt;
  op_t                op_q;
  logic [W-1:0]       data_q;
  logic [W-1:0]       stk [DEPTH];
  logic [3:0]         cnt;
  logic               ready_nxt;
  logic               accept;

  logic               ovf_d, unf_d;
  logic [W-1:0]       res_d;
  logic [2*W-1:0]     prod;
  logic               ovf_q, unf_q;
  logic [W-1:0]       res_q;
  logic [DEPTH*W-1:0] snap;

  assign accept = cmd_valid & cmd_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // cmd_ready is registered so it stays low through reset and rises one edge later
  always_comb begin
    ready_nxt = (state_nxt == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cmd_ready <= 1'b0;
    else        cmd_ready <= ready_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= OP_PUSH;
      data_q <= '0;
    end else if (state == IDLE && accept) begin
      op_q   <= op_t'(cmd_op);
      data_q <= cmd_data;
    end
  end

  // Legality and result, computed from the pre-update stack in EXEC
  always_comb begin
    ovf_d = 1'b0;
    unf_d = 1'b0;
    res_d = '0;
    prod  = stk[1] * stk[0];
    unique case (op_q)
      OP_PUSH: ovf_d = (cnt == 4'(DEPTH));
      OP_POP:  unf_d = (cnt == 4'd0);
      OP_ADD: begin
        unf_d = (cnt < 4'd2);
        res_d = stk[1] + stk[0];
      end
      OP_SUB: begin
        unf_d = (cnt < 4'd2);
        res_d = stk[1] - stk[0];
      end
      OP_MUL: begin
        unf_d = (cnt < 4'd2);
        res_d = prod[W-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      res_q <= '0;
    end else if (state == EXEC) begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      res_q <= res_d;
    end
  end

  // Stack update; vacated entries are zeroed so top reads 0 when empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) stk[i] <= '0;
      cnt     <= 4'd0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else if (state == WB) begin
      unique case (op_q)
        OP_PUSH: begin
          if (ovf_q) begin
            err_ovf <= 1'b1;
          end else begin
            for (int unsigned i = 1; i < DEPTH; i++) stk[i] <= stk[i-1];
            stk[0] <= data_q;
            cnt    <= cnt + 4'd1;
          end
        end
        OP_POP: begin
          if (unf_q) begin
            err_unf <= 1'b1;
          end else begin
            for (int unsigned i = 0; i < DEPTH-1; i++) stk[i] <= stk[i+1];
            stk[DEPTH-1] <= '0;
            cnt          <= cnt - 4'd1;
          end
        end
        OP_ADD, OP_SUB, OP_MUL: begin
          if (unf_q) begin
            err_unf <= 1'b1;
          end else begin
            stk[0] <= res_q;
            for (int unsigned i = 1; i < DEPTH-1; i++) stk[i] <= stk[i+1];
            stk[DEPTH-1] <= '0;
            cnt          <= cnt - 4'd1;
          end
        end
        OP_CLEAR: begin
          for (int unsigned i = 0; i < DEPTH; i++) stk[i] <= '0;
          cnt     <= 4'd0;
          err_ovf <= 1'b0;
          err_unf <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign depth = cnt;
  assign top   = (cnt != 4'd0) ? stk[0] : '0;

  always_comb begin
    snap = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      snap[i*W +: W] = (i < {28'd0, cnt}) ? stk[i] : EMPTY_NIBBLE;
    end
  end

`ifdef CALC_FRAME_SYNC_EN
  logic vblank_q;
  logic late_q;
  logic vb_rise;

  assign vb_rise = vblank & ~vblank_q;

  // A rise coinciding with WB captures the pre-update stack, so reload once more
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblank_q <= 1'b0;
      late_q   <= 1'b0;
      numbers  <= {DEPTH{EMPTY_NIBBLE}};
    end else begin
      vblank_q <= vblank;
      late_q   <= vb_rise && (state == WB);
      if (vb_rise || late_q) numbers <= snap;
    end
  end
`else
  logic unused_vblank;
  assign unused_vblank = vblank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) numbers <= {DEPTH{EMPTY_NIBBLE}};
    else        numbers <= snap;
  end
`endif

endmodule

// File: tb/tb_calc_stack_display_ctrl.sv
// Self-checking bench for calc_stack_display_ctrl: vector table, corner sequences,
// and random commands against a queue-based stack model.
module tb_calc_stack_display_ctrl;
  localparam int DEPTH = 15;
  localparam int W     = 4;
  localparam logic [59:0] ALL_F = 60'hFFFFF_FFFFF_FFFFF;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [W-1:0]      cmd_data;
  logic              vblank;
  logic [DEPTH*W-1:0] numbers;
  logic [3:0]        depth;
  logic [W-1:0]      top;
  logic              err_ovf;
  logic              err_unf;

  always #20 clk = ~clk;

  calc_stack_display_ctrl #(
    .DEPTH(DEPTH),
    .W(W),
    .EMPTY_NIBBLE(4'hF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_data(cmd_data),
    .vblank(vblank),
    .numbers(numbers),
    .depth(depth),
    .top(top),
    .err_ovf(err_ovf),
    .err_unf(err_unf)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: q[0] is top of stack
  int q[$];
  bit m_ovf, m_unf;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  data;
    logic [3:0]  d;
    logic [3:0]  t;
    logic        ovf;
    logic        unf;
    logic [59:0] nums;
  } vec_t;

  vec_t tbl[17];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic model_apply(input int op, input int data);
    int a, b;
    case (op)
      0: if (q.size() == DEPTH) m_ovf = 1; else q.push_front(data);
      1: if (q.size() == 0) m_unf = 1; else void'(q.pop_front());
      2, 3, 4: begin
        if (q.size() < 2) m_unf = 1;
        else begin
          b = q.pop_front();
          a = q.pop_front();
          if (op == 2)      q.push_front((a + b) % 16);
          else if (op == 3) q.push_front((a - b + 16) % 16);
          else              q.push_front((a * b) % 16);
        end
      end
      5: model_reset();
      default: ;
    endcase
  endtask

  function automatic logic [59:0] model_numbers();
    logic [59:0] r;
    r = '0;
    for (int i = 0; i < DEPTH; i++) r[i*4 +: 4] = (i < q.size()) ? 4'(q[i]) : 4'hF;
    return r;
  endfunction

  task automatic check_model(input string tag);
    check({tag, "_depth"}, 64'(depth), 64'(q.size()));
    check({tag, "_top"}, 64'(top), (q.size() > 0) ? 64'(q[0]) : 64'd0);
    check({tag, "_ovf"}, 64'(err_ovf), 64'(m_ovf));
    check({tag, "_unf"}, 64'(err_unf), 64'(m_unf));
    check({tag, "_numbers"}, 64'(numbers), 64'(model_numbers()));
  endtask

  // Issue one command, wait for completion, pulse vblank so both builds refresh numbers
  task automatic do_cmd(input logic [2:0] op, input logic [3:0] data);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) check("ready_timeout", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_data  = ~data;
    @(posedge clk); #1;
    @(posedge clk); #1;
    vblank = 1'b1;
    @(posedge clk); #1;
    vblank = 1'b0;
    @(posedge clk); #1;
    model_apply(int'(op), int'(data));
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int last, acc, cyc, r;
    logic [2:0] op;

    tbl[0]  = '{3'd0, 4'h3, 4'd1, 4'h3, 1'b0, 1'b0, 60'hFFFFF_FFFFF_FFFF3};
    tbl[1]  = '{3'd0, 4'h5, 4'd2, 4'h5, 1'b0, 1'b0, 60'hFFFFF_FFFFF_FFF35};
    tbl[2]  = '{3'd2, 4'h0, 4'd1, 4'h8, 1'b0, 1'b0, 60'hFFFFF_FFFFF_FFFF8};
    tbl[3]  = '{3'd5, 4'h0, 4'd0, 4'h0, 1'b0, 1'b0, ALL_F};
    tbl[4]  = '{3'd0, 4'h2, 4'd1, 4'h2, 1'b0, 1'b0, 60'hFFFFF_FFFFF_FFFF2};
    tbl[5]  = '{3'd0, 4'h7, 4'd2, 4'h7, 1'b0, 1'b0, 60'hFFFFF_FFFFF_FFF27};
    tbl[6]  = '{3'd3, 4'h0, 4'd1, 4'hB, 1'b0, 1'b0, 60'hFFFFF_FFFFF_FFFFB};
    tbl[7]  = '{3'd0, 4'h6, 4'd2, 4'h6, 1'b0, 1'b0, 60'hFFFFF_FFFFF_FFFB6};
    tbl[8]  = '{3'd0, 4'h5, 4'd3, 4'h5, 1'b0, 1'b0, 60'hFFFFF_FFFFF_FFB65};
    tbl[9]  = '{3'd4, 4'h0, 4'd2, 4'hE, 1'b0, 1'b0, 60'hFFFFF_FFFFF_FFFBE};
    tbl[10] = '{3'd5, 4'h0, 4'd0, 4'h0, 1'b0, 1'b0, ALL_F};
    tbl[11] = '{3'd1, 4'h0, 4'd0, 4'h0, 1'b0, 1'b1, ALL_F};
    tbl[12] = '{3'd0, 4'h1, 4'd1, 4'h1, 1'b0, 1'b1, 60'hFFFFF_FFFFF_FFFF1};
    tbl[13] = '{3'd2, 4'h0, 4'd1, 4'h1, 1'b0, 1'b1, 60'hFFFFF_FFFFF_FFFF1};
    tbl[14] = '{3'd5, 4'h0, 4'd0, 4'h0, 1'b0, 1'b0, ALL_F};
    tbl[15] = '{3'd0, 4'hF, 4'd1, 4'hF, 1'b0, 1'b0, ALL_F};
    tbl[16] = '{3'd6, 4'h4, 4'd1, 4'hF, 1'b0, 1'b0, ALL_F};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; vblank = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(cmd_ready), 64'd0);
    check("rst_depth", 64'(depth), 64'd0);
    check("rst_numbers", 64'(numbers), 64'(ALL_F));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready_after", 64'(cmd_ready), 64'd1);

    for (int i = 0; i < 17; i++) begin
      do_cmd(tbl[i].op, tbl[i].data);
      check($sformatf("vec%0d_depth", i), 64'(depth), 64'(tbl[i].d));
      check($sformatf("vec%0d_top", i), 64'(top), 64'(tbl[i].t));
      check($sformatf("vec%0d_ovf", i), 64'(err_ovf), 64'(tbl[i].ovf));
      check($sformatf("vec%0d_unf", i), 64'(err_unf), 64'(tbl[i].unf));
      check($sformatf("vec%0d_numbers", i), 64'(numbers), 64'(tbl[i].nums));
      check_model($sformatf("vec%0d_model", i));
    end

    // Fill to DEPTH then overflow
    do_cmd(3'd5, 4'h0);
    for (int i = 0; i < DEPTH; i++) do_cmd(3'd0, 4'(i));
    do_cmd(3'd0, 4'h5);
    check("ovf_flag", 64'(err_ovf), 64'd1);
    check("ovf_depth", 64'(depth), 64'd15);
    check("ovf_numbers", 64'(numbers), 64'(60'h01234_56789_ABCDE));
    check_model("ovf_model");

    // Display latency of a single PUSH
    do_cmd(3'd5, 4'h0);
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_data = 4'h9;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("lat_depth_wb", 64'(depth), 64'd1);
    check("lat_numbers_wb", 64'(numbers[3:0]), 64'hF);
`ifdef CALC_FRAME_SYNC_EN
    repeat (3) begin
      @(posedge clk); #1;
      check("fs_numbers_hold", 64'(numbers), 64'(ALL_F));
    end
    vblank = 1'b1;
    @(posedge clk); #1;
    vblank = 1'b0;
    check("fs_numbers_load", 64'(numbers[3:0]), 64'h9);
`else
    @(posedge clk); #1;
    check("lat_numbers_next", 64'(numbers[3:0]), 64'h9);
`endif
    model_apply(0, 9);

    // Back-to-back acceptance with cmd_valid held, then reset mid-command
    do_cmd(3'd5, 4'h0);
    last = -1; acc = 0; cyc = 0;
    cmd_op = 3'd0; cmd_data = 4'h1; cmd_valid = 1'b1;
    while (acc < 4 && cyc < 40) begin
      @(negedge clk);
      if (cmd_ready) begin
        if (last >= 0) check("accept_gap", 64'(cyc - last), 64'd3);
        cmd_data = 4'(acc + 1);
        acc++;
        last = cyc;
      end
      cyc++;
    end
    if (acc < 4) check("accept_timeout", 64'(acc), 64'd4);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("b2b_ready_exec", 64'(cmd_ready), 64'd0);
    check("b2b_depth", 64'(depth), 64'd3);
    rst_n = 1'b0;
    #1;
    check("arst_depth", 64'(depth), 64'd0);
    check("arst_top", 64'(top), 64'd0);
    check("arst_ready", 64'(cmd_ready), 64'd0);
    check("arst_numbers", 64'(numbers), 64'(ALL_F));
    check("arst_flags", 64'({err_ovf, err_unf}), 64'd0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_ready_after", 64'(cmd_ready), 64'd1);

    // Random commands against the model
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 19);
      if (r <= 8)       op = 3'd0;
      else if (r <= 11) op = 3'd1;
      else if (r <= 13) op = 3'd2;
      else if (r == 14) op = 3'd3;
      else if (r <= 16) op = 3'd4;
      else if (r == 17) op = 3'd5;
      else if (r == 18) op = 3'd6;
      else              op = 3'd7;
      do_cmd(op, 4'($urandom_range(0, 15)));
      check_model($sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
